// File: rtl/stopwatch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the tick stopwatch.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int c_BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [c_BCD_W-1:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = c_SEG_0;
            4'd1:    pattern = c_SEG_1;
            4'd2:    pattern = c_SEG_2;
            4'd3:    pattern = c_SEG_3;
            4'd4:    pattern = c_SEG_4;
            4'd5:    pattern = c_SEG_5;
            4'd6:    pattern = c_SEG_6;
            4'd7:    pattern = c_SEG_7;
            4'd8:    pattern = c_SEG_8;
            4'd9:    pattern = c_SEG_9;
            default: pattern = c_SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seg_scan
// Description : Multiplexed active-low seven-segment scanner for a BCD bus.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan
    import stopwatch_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [c_BCD_W*DIGITS-1:0]   bcd,
    output logic [6:0]                  seg,
    output logic [DIGITS-1:0]           an
);

    localparam int                 c_CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                 c_IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic [c_BCD_W-1:0]  w_digit;
    logic [DIGITS-1:0]   w_an;

    always_comb begin
        w_digit = '0;
        w_an    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_digit = bcd[i*c_BCD_W +: c_BCD_W];
                w_an[i] = 1'b0;
            end
        end
    end

    // seg/an are loaded from the same index in one register stage, so each
    // slot is a full SCAN_DIV cycles and the two never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_seg <= c_SEG_BLANK;
            r_an  <= '1;
        end else begin
            r_seg <= seg_decode(w_digit);
            r_an  <= w_an;
            if (r_cnt == c_CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule
`default_nettype wire

// File: rtl/tick_stopwatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tick_stopwatch
// Description : BCD stopwatch counting divider ticks, with multiplexed display.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick_in,
    input  logic                        start_stop,
    input  logic                        clr,
    output logic [c_BCD_W*DIGITS-1:0]   bcd,
    output logic                        running,
    output logic                        wrap,
    output logic [6:0]                  seg,
    output logic [DIGITS-1:0]           an
);

    logic                        r_tick_q;
    logic                        r_edge;
    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_running;
    logic                        r_wrap;
    logic [c_BCD_W*DIGITS-1:0]   r_bcd;
    logic [c_BCD_W*DIGITS-1:0]   w_bcd_inc;
    logic [c_BCD_W-1:0]          w_dig;
    logic                        w_carry;
    logic                        w_all_nines;
    logic                        w_count;

    assign w_count = r_edge && (r_state == ST_RUN);

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_IDLE;
        end else if (start_stop) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_RUN;
                ST_RUN:   w_state_nxt = ST_PAUSE;
                ST_PAUSE: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Ripple decimal increment; all-nines flags the roll-over to zero.
    always_comb begin
        w_bcd_inc   = r_bcd;
        w_dig       = '0;
        w_carry     = 1'b1;
        w_all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig = r_bcd[i*c_BCD_W +: c_BCD_W];
            if (w_dig != 4'd9) begin
                w_all_nines = 1'b0;
            end
            if (w_carry) begin
                if (w_dig == 4'd9) begin
                    w_bcd_inc[i*c_BCD_W +: c_BCD_W] = 4'd0;
                end else begin
                    w_bcd_inc[i*c_BCD_W +: c_BCD_W] = w_dig + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_q  <= 1'b0;
            r_edge    <= 1'b0;
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_tick_q  <= tick_in;
            r_edge    <= tick_in & ~r_tick_q;
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_wrap    <= 1'b0;
            if (clr) begin
                r_bcd <= '0;
            end else if (w_count) begin
                r_bcd  <= w_bcd_inc;
                r_wrap <= w_all_nines;
            end
        end
    end

    seg_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk (clk),
        .rst (rst),
        .bcd (r_bcd),
        .seg (seg),
        .an  (an)
    );

    assign bcd     = r_bcd;
    assign running = r_running;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire
